// File: rtl/serial_paralelo_pkg.sv
`default_nettype none
// ============================================================================
//  Module : serial_paralelo_pkg
//  Brief  : Shared PHY receive definitions: symbol width, COM idle symbol
//           and the deserializer state encoding.
//  Rev    : 1.0  initial release
// ============================================================================
package serial_paralelo_pkg;

  localparam int SYM_W = 8;

  // Idle/alignment symbol, shared with the transmit serializer
  localparam logic [SYM_W-1:0] COM_SYMBOL = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_paralelo_com_detect.sv
`default_nettype none
// ============================================================================
//  Module : serial_paralelo_com_detect
//  Brief  : 8-bit window comparator flagging the COM idle symbol.
//  Rev    : 1.0  initial release
// ============================================================================
module serial_paralelo_com_detect #(
  parameter logic [7:0] COM_SYMBOL = serial_paralelo_pkg::COM_SYMBOL
) (
  input  logic [7:0] window,
  output logic       is_com
);

  assign is_com = (window == COM_SYMBOL);

endmodule
`default_nettype wire

// File: rtl/serial_paralelo.sv
`default_nettype none
// ============================================================================
//  Module : serial_paralelo
//  Brief  : Receive deserializer. Hunts for COM at every bit offset, locks
//           after COM_NEEDED aligned COMs, then strobes out one byte every
//           8 bit-clocks. Once active, only reset leaves the locked state.
//  Rev    : 1.0  initial release
// ============================================================================
module serial_paralelo #(
  parameter logic [7:0] COM_SYMBOL = serial_paralelo_pkg::COM_SYMBOL,
  parameter int         COM_NEEDED = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
);

  import serial_paralelo_pkg::*;

  localparam logic [3:0] COM_TARGET = 4'(COM_NEEDED);

  // Only 7 history bits are needed: the 8th bit of the window is data_in itself
  logic [SYM_W-2:0] sr;
  logic [SYM_W-1:0] window;
  logic             is_com;
  state_t           state;
  state_t           next_state;
  logic [2:0]       bit_cnt;
  logic [3:0]       com_cnt;
  logic             boundary;
  logic             lock_done;
  logic             emit;

  // Byte completing on this edge
  assign window    = {sr, data_in};
  assign boundary  = (bit_cnt == 3'd7);
  assign lock_done = ((com_cnt + 4'd1) == COM_TARGET);

  serial_paralelo_com_detect #(
    .COM_SYMBOL (COM_SYMBOL)
  ) u_com_detect (
    .window (window),
    .is_com (is_com)
  );

  // State register
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: free search, aligned COM counting, then permanent lock
  always_comb begin
    next_state = state;
    case (state)
      SEARCH: begin
        if (is_com) begin
          next_state = (COM_TARGET == 4'd1) ? ACTIVE : LOCKING;
        end
      end
      LOCKING: begin
        if (boundary) begin
          if (!is_com) begin
            next_state = SEARCH;
          end else if (lock_done) begin
            next_state = ACTIVE;
          end
        end
      end
      ACTIVE:  next_state = ACTIVE;
      default: next_state = SEARCH;
    endcase
  end

  // FSM outputs: lock indication and byte-emit qualifier
  always_comb begin
    active = (state == ACTIVE);
    emit   = (state == ACTIVE) && boundary;
  end

  // Shift register, bit position and aligned-COM counters
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr      <= '0;
      bit_cnt <= 3'd0;
      com_cnt <= 4'd0;
    end else begin
      sr <= window[SYM_W-2:0];
      case (state)
        SEARCH: begin
          if (is_com) begin
            bit_cnt <= 3'd0;
            com_cnt <= 4'd1;
          end
        end
        LOCKING: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (!is_com) begin
              com_cnt <= 4'd0;
            end else if (com_cnt < COM_TARGET) begin
              com_cnt <= com_cnt + 4'd1;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
        end
        default: begin
          bit_cnt <= 3'd0;
          com_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Parallel output registers, loaded on each aligned boundary while active
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      byte_stb  <= 1'b0;
    end else begin
      byte_stb <= emit;
      if (emit) begin
        data_out  <= window;
        valid_out <= !is_com;
      end
    end
  end

endmodule
`default_nettype wire
